gnt_data_mux: RTL and testbench
===============================

GNT_DATA_MUX -- requirements
Module: gnt_data_mux

Interface
REQ-001 Parameter NUM_REQ, default 10: number of requestor ports; legal range 2..32.
REQ-002 Parameter DATA_W, default 32: payload width per port.
REQ-003 Parameter SRC_W, default $clog2(NUM_REQ): width of the source index.
REQ-004 Port clk  input  1: single clock; all state updates on rising edge.
REQ-005 Port rst_b  input  1: reset, asynchronous and active-low.
REQ-006 Port in_valid  input  NUM_REQ: per-port payload valid.
REQ-007 Port in_data  input  NUM_REQ x DATA_W: per-port payload, unpacked array.
REQ-008 Port in_ready  output  NUM_REQ: per-port accept strobe; payload consumed when in_valid[i] & in_ready[i].
REQ-009 Port arb_req  output  NUM_REQ: request vector driven to the weighted round-robin arbiter.
REQ-010 Port arb_gnt  input  NUM_REQ: grant vector from the arbiter, same cycle as arb_req (combinational return path).
REQ-011 Port out_valid  output  1: output payload valid.
REQ-012 Port out_data  output  DATA_W: output payload.
REQ-013 Port out_src  output  SRC_W: index of the port that supplied out_data.
REQ-014 Port out_ready  input  1: downstream accept; pop when out_valid & out_ready.
REQ-015 Port gnt_err  output  1: sticky protocol-error flag.

Function
REQ-016 Two-entry output FIFO holds {data, src}; occupancy count is 0..2, registered.
REQ-017 arb_req[i] = in_valid[i] & (count < 2) & !gnt_err; no combinational path from out_ready to arb_req.
REQ-018 A grant is legal when arb_gnt is one-hot and arb_gnt & arb_req is nonzero; an all-zero arb_gnt is an idle cycle.
REQ-019 On a legal grant to port k: in_ready[k]=1 and all other in_ready bits are 0; in_data[k] and k are pushed the same cycle.
REQ-020 in_ready is all zeros for an idle or illegal grant; an illegal grant pushes nothing.
REQ-021 Illegal grant (more than one bit set, or a bit set where arb_req is 0) sets gnt_err on the next edge; gnt_err then holds and forces arb_req to 0 until reset.
REQ-022 Latency is one cycle: a payload pushed at edge N appears on out_valid/out_data/out_src after edge N and before edge N+1.
REQ-023 out_valid = (count != 0); out_data/out_src always show the head entry.
REQ-024 Push and pop in the same cycle leave count unchanged and preserve order.
REQ-025 A push is impossible at count==2 by REQ-017; a pop with count==0 is ignored.
REQ-026 Order: the output order is the grant order; no reordering or dropping.
REQ-027 in_data of non-granted ports is ignored; out_data is don't-care when out_valid=0.

Reset
REQ-028 While rst_b is low: count=0, out_valid=0, gnt_err=0, FIFO pointers=0, out_src=0 and out_data=0.
REQ-029 In-flight FIFO entries are discarded when reset asserts mid-operation; no partial push completes.
REQ-030 Outputs are valid from the first rising clk edge after rst_b deasserts.

Structure
REQ-031 Shared package arb_pkg holds the DATA_W default and the fifo-entry struct {data, src}.
REQ-032 One sub-module is used: sync_fifo2, a two-entry registered FIFO with push, pop, count, and head.
REQ-033 The top level contains only the grant check, req gating, and data mux; the arbiter is instantiated by the parent, not by this block.

Verification
REQ-034 in_valid=0x005, arb_gnt=0x001 with in_data[0]=0xA5 -> in_ready=0x001; next cycle out_valid=1, out_data=0xA5, out_src=0.
REQ-035 out_ready=0 and two legal grants -> count=2, arb_req=0 on the following cycle even with in_valid=0x3FF; out_ready=1 pops in order.
REQ-036 count=1, push and pop in the same cycle -> count stays 1, and the second payload becomes the head.
REQ-037 arb_gnt=0x003 -> no push, in_ready=0, gnt_err=1 next cycle; arb_req=0 thereafter until rst_b pulses low.
REQ-038 arb_gnt=0x004 with arb_req[2]=0 -> gnt_err=1; the FIFO is unchanged.
REQ-039 Reset asserted with count=2 -> out_valid=0 immediately (async); after release, a fresh grant gives latency 1.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared geometry defaults, fifo entry type and grant helper
package arb_pkg;

   localparam int ARB_NUM_REQ = 10;
   localparam int ARB_DATA_W  = 32;
   localparam int ARB_SRC_W   = $clog2(ARB_NUM_REQ);

   // Entry held by the output FIFO at the default geometry: payload plus the
   // index of the port that supplied it.
   typedef struct packed {
      logic [ARB_DATA_W-1:0] data;
      logic [ARB_SRC_W-1:0]  src;
   } fifo_entry_t;

   // True when exactly one bit is set; grant vectors are at most 32 wide.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/sync_fifo2.sv
// rtl/sync_fifo2.sv - two-entry registered FIFO with push, pop, count and head
module sync_fifo2
   import arb_pkg::*;
#(
   parameter type T = fifo_entry_t
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       push_i,
   input  T           din_i,
   input  logic       pop_i,
   output logic [1:0] count_o,
   output T           head_o
);

   T           mem_q [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] count_q, count_d;
   logic       do_push, do_pop;

   // Full blocks a push and empty blocks a pop, so count never leaves 0..2.
   always_comb begin
      do_push  = push_i & (count_q != 2'd2);
      do_pop   = pop_i & (count_q != 2'd0);
      wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointers; reset clears entries so the head reads zero.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/gnt_data_mux.sv
// rtl/gnt_data_mux.sv - grant check, request gating and payload mux into a 2-deep FIFO
module gnt_data_mux
   import arb_pkg::*;
#(
   parameter int NUM_REQ = ARB_NUM_REQ,
   parameter int DATA_W  = ARB_DATA_W,
   parameter int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [NUM_REQ-1:0] in_valid,
   input  logic [DATA_W-1:0] in_data [NUM_REQ],
   output logic [NUM_REQ-1:0] in_ready,
   output logic [NUM_REQ-1:0] arb_req,
   input  logic [NUM_REQ-1:0] arb_gnt,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [SRC_W-1:0]  out_src,
   input  logic              out_ready,
   output logic              gnt_err
);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [SRC_W-1:0]  src;
   } entry_t;

   logic [31:0]       gnt_ext;
   logic              gnt_legal;
   logic              gnt_illegal;
   logic [SRC_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] gnt_data;
   logic [1:0]        fifo_count;
   entry_t            push_entry;
   entry_t            fifo_head;
   logic              pop;
   logic              gnt_err_q, gnt_err_d;

   // Requests depend only on registered state and in_valid, never on out_ready.
   assign arb_req = in_valid & {NUM_REQ{(fifo_count != 2'd2) & ~gnt_err_q}};

   // A grant is accepted only when one-hot and aimed at a live request.
   always_comb begin
      gnt_ext     = 32'(arb_gnt);
      gnt_legal   = is_onehot(gnt_ext) & (|(arb_gnt & arb_req));
      gnt_illegal = (|arb_gnt) & ~gnt_legal;
   end

   // Select the granted port's payload and index; meaningful only when legal.
   always_comb begin
      gnt_idx  = '0;
      gnt_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (arb_gnt[i]) begin
            gnt_idx  = SRC_W'(i);
            gnt_data = in_data[i];
         end
      end
      push_entry.data = gnt_data;
      push_entry.src  = gnt_idx;
   end

   assign in_ready = gnt_legal ? arb_gnt : '0;
   assign pop      = out_ready & (fifo_count != 2'd0);

   // Protocol error is sticky until reset and shuts off all requests.
   always_comb begin
      gnt_err_d = gnt_err_q | gnt_illegal;
   end

   // Error flag register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         gnt_err_q <= 1'b0;
      end else begin
         gnt_err_q <= gnt_err_d;
      end
   end

   sync_fifo2 #(
      .T (entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_b   (rst_b),
      .push_i  (gnt_legal),
      .din_i   (push_entry),
      .pop_i   (pop),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   assign out_valid = (fifo_count != 2'd0);
   assign out_data  = fifo_head.data;
   assign out_src   = fifo_head.src;
   assign gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_gnt_data_mux.sv
// tb/tb_gnt_data_mux.sv - directed self-checking bench for gnt_data_mux
module tb_gnt_data_mux;

   localparam int NR = 10;
   localparam int DW = 32;
   localparam int SW = 4;

   logic          clk;
   logic          rst_b;
   logic [NR-1:0] in_valid;
   logic [DW-1:0] in_data [NR];
   logic [NR-1:0] in_ready;
   logic [NR-1:0] arb_req;
   logic [NR-1:0] arb_gnt;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [SW-1:0] out_src;
   logic          out_ready;
   logic          gnt_err;

   int tests_run;
   int tests_failed;

   gnt_data_mux #(
      .NUM_REQ (NR),
      .DATA_W  (DW)
   ) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .arb_req   (arb_req),
      .arb_gnt   (arb_gnt),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_ready (out_ready),
      .gnt_err   (gnt_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_b        = 1'b0;
      in_valid     = '0;
      arb_gnt      = '0;
      out_ready    = 1'b0;
      for (int i = 0; i < NR; i++) in_data[i] = 32'h1000 + i;

      // Reset state
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_gnt_err", gnt_err, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_in_ready", in_ready, 0);
      tick();
      rst_b = 1'b1;
      tick();

      // Single legal grant, latency one
      in_valid   = 10'h005;
      in_data[0] = 32'hA5;
      arb_gnt    = 10'h001;
      #1;
      chk("g1_arb_req", arb_req, 10'h005);
      chk("g1_in_ready", in_ready, 10'h001);
      tick();
      arb_gnt  = '0;
      in_valid = '0;
      #1;
      chk("g1_out_valid", out_valid, 1);
      chk("g1_out_data", out_data, 32'hA5);
      chk("g1_out_src", out_src, 0);
      out_ready = 1'b1;
      tick();
      chk("g1_popped", out_valid, 0);
      out_ready = 1'b0;

      // Fill to two, requests drop, then pop in order
      in_valid   = 10'h3FF;
      in_data[3] = 32'h33;
      in_data[9] = 32'h99;
      arb_gnt    = 10'h008;
      #1;
      chk("f_in_ready0", in_ready, 10'h008);
      tick();
      arb_gnt = 10'h200;
      #1;
      chk("f_arb_req_c1", arb_req, 10'h3FF);
      chk("f_in_ready1", in_ready, 10'h200);
      tick();
      arb_gnt = '0;
      #1;
      chk("f_arb_req_full", arb_req, 10'h000);
      chk("f_head0_data", out_data, 32'h33);
      chk("f_head0_src", out_src, 3);
      out_ready = 1'b1;
      #1;
      chk("f_req_no_comb_ready", arb_req, 10'h000);
      tick();
      chk("f_head1_data", out_data, 32'h99);
      chk("f_head1_src", out_src, 9);
      chk("f_arb_req_c1b", arb_req, 10'h3FF);
      tick();
      chk("f_empty", out_valid, 0);
      out_ready = 1'b0;

      // Push and pop together at count one
      in_data[1] = 32'h11;
      in_data[4] = 32'h44;
      arb_gnt    = 10'h002;
      tick();
      chk("pp_head_first", out_data, 32'h11);
      arb_gnt   = 10'h010;
      out_ready = 1'b1;
      #1;
      chk("pp_in_ready", in_ready, 10'h010);
      tick();
      arb_gnt = '0;
      #1;
      chk("pp_out_valid", out_valid, 1);
      chk("pp_head_data", out_data, 32'h44);
      chk("pp_head_src", out_src, 4);
      chk("pp_arb_req", arb_req, 10'h3FF);
      tick();
      chk("pp_drained", out_valid, 0);

      // Pop while empty is ignored (no underflow)
      tick();
      chk("ue_still_empty", out_valid, 0);
      out_ready = 1'b0;
      arb_gnt   = 10'h001;
      tick();
      arb_gnt = '0;
      #1;
      chk("ue_one_entry", out_valid, 1);
      out_ready = 1'b1;
      tick();
      chk("ue_back_empty", out_valid, 0);
      out_ready = 1'b0;

      // Multi-bit grant is illegal
      arb_gnt = 10'h003;
      #1;
      chk("mh_in_ready", in_ready, 10'h000);
      chk("mh_err_pre", gnt_err, 0);
      tick();
      arb_gnt = '0;
      #1;
      chk("mh_err", gnt_err, 1);
      chk("mh_no_push", out_valid, 0);
      chk("mh_req_off", arb_req, 10'h000);
      tick();
      chk("mh_err_sticky", gnt_err, 1);
      chk("mh_req_off2", arb_req, 10'h000);
      rst_b = 1'b0;
      #1;
      chk("mh_err_cleared", gnt_err, 0);
      tick();
      rst_b = 1'b1;
      #1;
      chk("mh_req_back", arb_req, 10'h3FF);

      // Grant to a non-requesting port is illegal, FIFO untouched
      in_valid   = 10'h3FB;
      in_data[0] = 32'h1234;
      in_data[2] = 32'h2222;
      arb_gnt    = 10'h001;
      tick();
      arb_gnt = 10'h004;
      #1;
      chk("nr_in_ready", in_ready, 10'h000);
      tick();
      arb_gnt = '0;
      #1;
      chk("nr_err", gnt_err, 1);
      chk("nr_head_data", out_data, 32'h1234);
      chk("nr_head_src", out_src, 0);
      out_ready = 1'b1;
      tick();
      chk("nr_only_one", out_valid, 0);
      out_ready = 1'b0;

      // Async reset with two entries, then a fresh grant
      rst_b = 1'b0;
      tick();
      rst_b    = 1'b1;
      in_valid = 10'h3FF;
      arb_gnt  = 10'h001;
      tick();
      arb_gnt = 10'h002;
      tick();
      arb_gnt = '0;
      #1;
      chk("ar_full_req", arb_req, 10'h000);
      #1;
      rst_b = 1'b0;
      #1;
      chk("ar_out_valid", out_valid, 0);
      chk("ar_out_data", out_data, 0);
      chk("ar_out_src", out_src, 0);
      tick();
      rst_b      = 1'b1;
      in_data[7] = 32'h77;
      arb_gnt    = 10'h080;
      tick();
      arb_gnt = '0;
      #1;
      chk("ar_fresh_valid", out_valid, 1);
      chk("ar_fresh_data", out_data, 32'h77);
      chk("ar_fresh_src", out_src, 7);
      out_ready = 1'b1;
      tick();
      chk("ar_no_stale", out_valid, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
